// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM states, IF/ID payload and the NOP bubble.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b.pc       = 32'h0;
      b.pc_plus4 = 32'h0;
      b.instr    = NOP_INSTR;
      b.valid    = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with its next-PC mux (sequential PC+4 or word-aligned redirect).
module pc_register
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        redirect_req_i,
   input  logic [31:0] redirect_target_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o
);

   logic [31:0] pc_q, pc_d;

   assign pc_plus4_o = pc_q + 32'd4;
   assign pc_o       = pc_q;

   always_comb begin
      pc_d = pc_q;
      if (en_i) begin
         // Redirect targets are forced word-aligned; sequential fetch wraps mod 2^32.
         pc_d = redirect_req_i ? (redirect_target_i & 32'hFFFF_FFFC) : pc_plus4_o;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pc_q <= RESET_VECTOR;
      else       pc_q <= pc_d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: BOOT/RUN/HALT control, IF/ID pipeline register and fetch counter.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        pc_write_en_i,
   input  logic        if_id_write_en_i,
   input  logic        if_id_flush_i,
   input  logic        redirect_req_i,
   input  logic [31:0] redirect_target_i,
   input  logic        halt_detected_i,
   input  logic        resume_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc_plus4_o,
   output logic [31:0] if_id_instr_o,
   output logic        if_id_valid_o,
   output logic        halted_o,
   output logic [31:0] fetch_count_o
);

   fetch_state_e state_q;
   logic         halted_q;
   if_id_t       if_id_q, if_id_d;
   logic [31:0]  fetch_count_q, fetch_count_d;
   logic [31:0]  pc, pc_plus4;
   logic         pc_en;

   // The PC only advances in RUN; BOOT and HALT freeze it whatever the hazard unit says.
   assign pc_en = (state_q == RUN) && pc_write_en_i;

   pc_register #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .en_i              (pc_en),
      .redirect_req_i    (redirect_req_i),
      .redirect_target_i (redirect_target_i),
      .pc_o              (pc),
      .pc_plus4_o        (pc_plus4)
   );

   assign imem_addr_o = pc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= BOOT;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            BOOT: begin
               state_q  <= RUN;
               halted_q <= 1'b0;
            end
            RUN: begin
               if (halt_detected_i) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end
            end
            HALT: begin
               // A fresh halt in the same cycle as resume wins.
               if (resume_i && !halt_detected_i) begin
                  state_q  <= RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= BOOT;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      if_id_d       = if_id_q;
      fetch_count_d = fetch_count_q;
      if (state_q != RUN || if_id_flush_i) begin
         if_id_d = if_id_bubble();
      end else if (if_id_write_en_i) begin
         if_id_d.pc       = pc;
         if_id_d.pc_plus4 = pc_plus4;
         if_id_d.instr    = imem_rdata_i;
         if_id_d.valid    = 1'b1;
         fetch_count_d    = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if_id_q       <= if_id_bubble();
         fetch_count_q <= 32'h0;
      end else begin
         if_id_q       <= if_id_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign if_id_pc_o       = if_id_q.pc;
   assign if_id_pc_plus4_o = if_id_q.pc_plus4;
   assign if_id_instr_o    = if_id_q.instr;
   assign if_id_valid_o    = if_id_q.valid;
   assign halted_o         = halted_q;
   assign fetch_count_o    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model queues the expected post-edge state per cycle.
module tb_fetch_stage;
   import riscv_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write_en, if_id_write_en, if_id_flush, redirect_req;
   logic [31:0] redirect_target;
   logic        halt_detected, resume;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;
   logic        if_id_valid, halted;

   always #5 clk = ~clk;

   assign imem_rdata = 32'hA000_0000 + imem_addr;

   fetch_stage #(.RESET_VECTOR(RV)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .pc_write_en_i     (pc_write_en),
      .if_id_write_en_i  (if_id_write_en),
      .if_id_flush_i     (if_id_flush),
      .redirect_req_i    (redirect_req),
      .redirect_target_i (redirect_target),
      .halt_detected_i   (halt_detected),
      .resume_i          (resume),
      .imem_addr_o       (imem_addr),
      .imem_rdata_i      (imem_rdata),
      .if_id_pc_o        (if_id_pc),
      .if_id_pc_plus4_o  (if_id_pc_plus4),
      .if_id_instr_o     (if_id_instr),
      .if_id_valid_o     (if_id_valid),
      .halted_o          (halted),
      .fetch_count_o     (fetch_count)
   );

   typedef struct {
      logic [31:0] pc, ipc, ipc4, instr, cnt;
      logic        valid, halted;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state
   int          m_st;   // 0 BOOT, 1 RUN, 2 HALT
   logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
   logic        m_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_pc = RV; m_cnt = 32'h0;
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP_INSTR; m_valid = 1'b0;
   endtask

   task automatic model_bubble();
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP_INSTR; m_valid = 1'b0;
   endtask

   task automatic step(input logic pwe, input logic iwe, input logic fl, input logic rr,
                       input logic [31:0] tgt, input logic hd, input logic rs);
      exp_t e, o;
      int   nst;
      logic [31:0] cur_pc;
      pc_write_en = pwe; if_id_write_en = iwe; if_id_flush = fl;
      redirect_req = rr; redirect_target = tgt; halt_detected = hd; resume = rs;
      cur_pc = m_pc;
      nst = m_st;
      case (m_st)
         0: begin nst = 1; model_bubble(); end
         1: begin
            if (pwe) m_pc = rr ? {tgt[31:2], 2'b00} : cur_pc + 32'd4;
            if (fl) model_bubble();
            else if (iwe) begin
               m_ipc = cur_pc; m_ipc4 = cur_pc + 32'd4;
               m_instr = 32'hA000_0000 + cur_pc; m_valid = 1'b1;
               m_cnt = m_cnt + 32'd1;
            end
            if (hd) nst = 2;
         end
         default: begin
            model_bubble();
            if (rs && !hd) nst = 1;
         end
      endcase
      m_st = nst;
      e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.instr = m_instr;
      e.cnt = m_cnt; e.valid = m_valid; e.halted = (nst == 2);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL sb_empty got=0 exp=1");
      end else begin
         o = sbq.pop_front();
         chk("pc",     imem_addr,             o.pc);
         chk("ifpc",   if_id_pc,              o.ipc);
         chk("ifpc4",  if_id_pc_plus4,        o.ipc4);
         chk("instr",  if_id_instr,           o.instr);
         chk("valid",  {31'h0, if_id_valid},  {31'h0, o.valid});
         chk("halted", {31'h0, halted},       {31'h0, o.halted});
         chk("count",  fetch_count,           o.cnt);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"},    imem_addr,                  RV);
      chk({tag, "_valid"}, {31'h0, if_id_valid},       32'h0);
      chk({tag, "_instr"}, if_id_instr,                NOP_INSTR);
      chk({tag, "_ifpc"},  if_id_pc,                   32'h0);
      chk({tag, "_cnt"},   fetch_count,                32'h0);
      chk({tag, "_halt"},  {31'h0, halted},            32'h0);
      chk({tag, "_state"}, 32'(dut.state_q),           32'(BOOT));
   endtask

   initial begin
      rst = 1'b1;
      pc_write_en = 1'b0; if_id_write_en = 1'b0; if_id_flush = 1'b0;
      redirect_req = 1'b0; redirect_target = 32'h0; halt_detected = 1'b0; resume = 1'b0;
      model_reset();
      #12;
      chk_reset("rst");
      rst = 1'b0;

      // Boot then straight-line fetch: PC 0,0,4,8,C
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 32'h0, 0, 0);
      chk("boot_cnt3", fetch_count, 32'd3);
      chk("boot_pcC",  imem_addr,   32'h0000_000C);

      // Load-use stall
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 32'h0, 0, 0);
      chk("stall_cnt", fetch_count, 32'd3);

      // Redirect with flush to an unaligned target
      step(1, 1, 1, 1, 32'h0000_0103, 0, 0);
      chk("redir_pc",  imem_addr, 32'h0000_0100);
      chk("redir_bub", {31'h0, if_id_valid}, 32'h0);
      step(1, 1, 0, 0, 32'h0, 0, 0);
      chk("redir_lat", if_id_pc, 32'h0000_0100);

      // Move to PC=0x10 and halt there
      step(1, 1, 1, 1, 32'h0000_0010, 0, 0);
      step(0, 1, 1, 0, 32'h0, 1, 0);
      chk("halt_flag", {31'h0, halted}, 32'h1);
      for (int i = 0; i < 5; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 0, 0);
      chk("halt_pc", imem_addr, 32'h0000_0010);
      step(1, 1, 0, 0, 32'h0, 1, 1);
      chk("halt_hold", {31'h0, halted}, 32'h1);
      step(1, 1, 0, 0, 32'h0, 0, 1);
      chk("resume", {31'h0, halted}, 32'h0);
      step(1, 1, 0, 0, 32'h0, 0, 0);
      chk("resume_pc", if_id_pc, 32'h0000_0010);

      // Counter wrap
      force dut.fetch_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_count_q;
      m_cnt = 32'hFFFF_FFFF;
      step(1, 1, 0, 0, 32'h0, 0, 0);
      chk("cnt_wrap", fetch_count, 32'h0);

      // Randomised traffic
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
              $urandom, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0));

      // Make sure we end in HALT at a nonzero PC, then reset asynchronously
      step(1, 1, 1, 1, 32'h0000_0204, 0, 1);
      step(1, 1, 1, 1, 32'h0000_0204, 0, 1);
      step(0, 1, 1, 0, 32'h0, 1, 0);
      chk("pre_rst_halt", {31'h0, halted}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset("async");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0, 0, 0);
      chk("post_rst_cnt", fetch_count, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
